// File: rtl/i2c_master_wr.sv
// I2C write master: START, 7-bit address + write bit, up to MAX_BYTES data bytes, STOP.
// The slave must ACK every byte. On a NACK the master goes straight to STOP and sets nack.
// Each SCL bit period is four quarters (Q0..Q3) of CLK_DIV clk cycles each.
//
// Ports:
//   clk, rst_n  - system clock; synchronous active-low reset
//   start       - transfer request, accepted only while idle
//   dev_addr    - 7-bit target address, latched when a start is accepted
//   num_bytes   - number of data bytes (clamped to MAX_BYTES, 0 = address-only probe)
//   tx_data     - data byte, latched in every cycle where tx_ready=1
//   tx_ready    - one-cycle pulse: tx_data is being consumed this cycle
//   busy        - high while a transfer is in progress
//   done        - one-cycle pulse on the last clk of STOP
//   nack        - last transfer aborted on a NACK; cleared when the next start is accepted
//   scl_o/sda_o - open-drain drives (0 = pull low, 1 = release)
//   sda_i       - sampled SDA pad level
module i2c_master_wr #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned MAX_BYTES = 4,
   parameter int unsigned LEN_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [6:0]       dev_addr,
   input  logic [LEN_W-1:0] num_bytes,
   input  logic [7:0]       tx_data,
   output logic             tx_ready,
   output logic             busy,
   output logic             done,
   output logic             nack,
   output logic             scl_o,
   output logic             sda_o,
   input  logic             sda_i
);

   localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BYTES);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StAddr,
      StAddrAck,
      StData,
      StDataAck,
      StStop
   } state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       qtr_q, qtr_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;      // bits being shifted out, MSB first
   logic [7:0]       byte_q, byte_d;  // first data byte, held through the address phase
   logic [LEN_W-1:0] rem_q, rem_d;    // data bytes not yet fully sent
   logic             ack_q, ack_d;
   logic             nack_q, nack_d;

   logic [LEN_W-1:0] len_clamp;
   logic             qtr_end;
   logic             bit_end;

   assign len_clamp = (num_bytes > MAX_LEN) ? MAX_LEN : num_bytes;
   assign qtr_end   = (div_q == DIV_LAST);
   assign bit_end   = qtr_end && (qtr_q == 2'd3);
   assign busy      = (state_q != StIdle);
   assign nack      = nack_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         div_q   <= '0;
         qtr_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         byte_q  <= '0;
         rem_q   <= '0;
         ack_q   <= 1'b0;
         nack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         byte_q  <= byte_d;
         rem_q   <= rem_d;
         ack_q   <= ack_d;
         nack_q  <= nack_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      qtr_d    = qtr_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      byte_d   = byte_q;
      rem_d    = rem_q;
      ack_d    = ack_q;
      nack_d   = nack_q;
      tx_ready = 1'b0;
      done     = 1'b0;
      scl_o    = 1'b1;
      sda_o    = 1'b1;

      // Bit timing runs in every active state. The quarter index wraps to Q0 at the end of STOP,
      // so the counters are back at zero when the FSM returns to idle.
      if (state_q != StIdle) begin
         div_d = qtr_end ? '0 : div_q + 1'b1;
         if (qtr_end) begin
            qtr_d = qtr_q + 2'd1;
         end
         // Sample SDA on the last clk of Q2, while SCL is high.
         if (qtr_end && (qtr_q == 2'd2)) begin
            ack_d = sda_i;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StStart;
               div_d   = '0;
               qtr_d   = '0;
               bit_d   = '0;
               sh_d    = {dev_addr, 1'b0};
               rem_d   = len_clamp;
               nack_d  = 1'b0;
               if (len_clamp != '0) begin
                  tx_ready = 1'b1;
                  byte_d   = tx_data;
               end
            end
         end

         StStart: begin
            // SDA falls at Q2 with SCL still high: the START condition.
            sda_o = ~qtr_q[1];
            if (bit_end) begin
               state_d = StAddr;
            end
         end

         StAddr: begin
            scl_o = qtr_q[1];
            sda_o = sh_q[7];
            if (bit_end) begin
               sh_d  = {sh_q[6:0], 1'b0};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = StAddrAck;
               end
            end
         end

         StData: begin
            scl_o = qtr_q[1];
            sda_o = sh_q[7];
            if (bit_end) begin
               sh_d  = {sh_q[6:0], 1'b0};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = StDataAck;
                  rem_d   = rem_q - 1'b1;
               end
            end
         end

         StAddrAck: begin
            scl_o = qtr_q[1];
            if (bit_end) begin
               if (ack_q) begin
                  nack_d  = 1'b1;
                  state_d = StStop;
               end else if (rem_q != '0) begin
                  state_d = StData;
                  sh_d    = byte_q;
               end else begin
                  state_d = StStop;
               end
            end
         end

         StDataAck: begin
            scl_o = qtr_q[1];
            if (bit_end) begin
               if (ack_q) begin
                  nack_d  = 1'b1;
                  state_d = StStop;
               end else if (rem_q != '0) begin
                  // The next byte is fetched only after the previous one has been ACKed.
                  state_d  = StData;
                  tx_ready = 1'b1;
                  byte_d   = tx_data;
                  sh_d     = tx_data;
               end else begin
                  state_d = StStop;
               end
            end
         end

         StStop: begin
            // SDA rises at Q3 with SCL high: the STOP condition.
            scl_o = qtr_q[1];
            sda_o = (qtr_q == 2'd3);
            if (bit_end) begin
               done    = 1'b1;
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_i2c_master_wr.sv
// Self-checking bench for i2c_master_wr. It contains a behavioural I2C slave that decodes
// START/STOP, collects bytes and ACKs or NACKs a chosen frame. A per-transfer reference model
// gives the expected bytes on the wire, the number of tx_ready pulses, the done latency and
// the nack status.
module tb_i2c_master_wr;

   localparam int unsigned CLK_DIV   = 2;
   localparam int unsigned MAX_BYTES = 4;
   localparam int unsigned LEN_W     = $clog2(MAX_BYTES + 1);

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             start     = 1'b0;
   logic [6:0]       dev_addr  = '0;
   logic [LEN_W-1:0] num_bytes = '0;
   logic [7:0]       tx_data;
   logic             tx_ready;
   logic             busy;
   logic             done;
   logic             nack;
   logic             scl_o;
   logic             sda_o;
   logic             sda_i;

   logic [7:0] pool [8];
   logic [2:0] pidx;
   int         rdy_total  = 0;
   int         rdy_lat    = 0;
   int         rdy_base   = 0;
   int         nack_frame = -1;
   logic       s_drv      = 1'b1;
   logic [7:0] rx_q [$];
   int         n_start    = 0;
   int         n_stop     = 0;
   int         viol       = 0;
   int         checks     = 0;
   int         errors     = 0;

   always #5 clk = ~clk;

   // Open-drain bus: the line is low if either side pulls it low.
   assign sda_i   = sda_o & s_drv;
   assign pidx    = 3'(rdy_lat - rdy_base);
   assign tx_data = pool[pidx];

   i2c_master_wr #(
      .CLK_DIV  (CLK_DIV),
      .MAX_BYTES(MAX_BYTES),
      .LEN_W    (LEN_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .dev_addr (dev_addr),
      .num_bytes(num_bytes),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .busy     (busy),
      .done     (done),
      .nack     (nack),
      .scl_o    (scl_o),
      .sda_o    (sda_o),
      .sda_i    (sda_i)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Count tx_ready pulses. The producer moves to the next byte only after the consuming edge.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_ready) begin
            rdy_total++;
            @(posedge clk);
            #1 rdy_lat++;
         end
      end
   end

   // Behavioural slave: frame 0 is the address byte and frame k is data byte k.
   initial begin : slave
      logic       scl_p;
      logic       sda_p;
      logic       act;
      logic       line;
      logic [7:0] sb;
      int         bits;
      int         frame;
      scl_p = 1'b1;
      sda_p = 1'b1;
      act   = 1'b0;
      sb    = '0;
      bits  = 0;
      frame = 0;
      forever begin
         @(negedge clk);
         line = sda_o & s_drv;
         if (scl_o && scl_p && sda_p && !line) begin
            n_start++;
            act   = 1'b1;
            bits  = 0;
            frame = 0;
            s_drv = 1'b1;
         end else if (scl_o && scl_p && !sda_p && line) begin
            n_stop++;
            act   = 1'b0;
            s_drv = 1'b1;
         end else if (act && scl_o && !scl_p) begin
            if (bits < 8) sb = {sb[6:0], line};
            else if (sda_o !== 1'b1) viol++;
            bits++;
         end else if (act && !scl_o && scl_p) begin
            if (bits == 8) begin
               s_drv = (frame == nack_frame) ? 1'b1 : 1'b0;
            end else if (bits == 9) begin
               s_drv = 1'b1;
               rx_q.push_back(sb);
               frame++;
               bits = 0;
            end
         end
         scl_p = scl_o;
         sda_p = sda_o & s_drv;
      end
   end

   // nf: frame the slave NACKs (-1 = ACK all). hold: keep start high for the whole transfer.
   task automatic run_xfer(input logic [6:0] addr, input int nb, input int nf, input bit hold,
                           input bit fixed);
      int         n;
      int         slots;
      int         exp_rdy;
      int         lat;
      int         k;
      int         rb;
      int         rx0;
      int         st0;
      int         sp0;
      int         v0;
      logic [7:0] exp_b [$];
      n       = (nb > int'(MAX_BYTES)) ? int'(MAX_BYTES) : nb;
      slots   = (nf >= 0) ? nf + 1 : n + 1;
      exp_rdy = (nf == 0) ? ((n > 0) ? 1 : 0) : ((nf > 0) ? nf : n);
      lat     = (2 + 9 * slots) * 4 * int'(CLK_DIV);
      for (int i = 0; i < 8; i++) pool[i] = 8'($urandom);
      if (fixed) begin
         pool[0] = 8'hA5;
         pool[1] = 8'h3C;
      end
      exp_b.push_back({addr, 1'b0});
      for (int i = 0; i < slots - 1; i++) exp_b.push_back(pool[i]);

      @(posedge clk);
      #1;
      check("idle_busy", int'(busy), 0);
      nack_frame = nf;
      rdy_base   = rdy_lat;
      rb         = rdy_total;
      rx0        = rx_q.size();
      st0        = n_start;
      sp0        = n_stop;
      v0         = viol;
      dev_addr   = addr;
      num_bytes  = LEN_W'(nb);
      start      = 1'b1;
      #1 check("rdy_accept", int'(tx_ready), (n > 0) ? 1 : 0);
      @(posedge clk);
      #1 if (!hold) start = 1'b0;
      @(negedge clk);
      check("busy_run", int'(busy), 1);
      check("nack_clr", int'(nack), 0);
      if (hold) check("hold_rdy", int'(tx_ready), 0);
      k = 1;
      while (!done && k < lat + 40) begin
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check("latency", k, lat);
      @(negedge clk);
      check("busy_end", int'(busy), 0);
      check("done_1cyc", int'(done), 0);
      check("nack", int'(nack), (nf >= 0) ? 1 : 0);
      check("rdy_count", rdy_total - rb, exp_rdy);
      check("rx_count", rx_q.size() - rx0, slots);
      for (int i = 0; i < slots && rx0 + i < rx_q.size(); i++) begin
         check($sformatf("rx_byte%0d", i), int'(rx_q[rx0 + i]), int'(exp_b[i]));
      end
      check("n_start", n_start - st0, 1);
      check("n_stop", n_stop - sp0, 1);
      check("ack_release", viol - v0, 0);
   endtask

   task automatic reset_mid();
      int dn;
      @(posedge clk);
      #1;
      nack_frame = -1;
      rdy_base   = rdy_lat;
      for (int i = 0; i < 8; i++) pool[i] = 8'($urandom);
      dev_addr  = 7'($urandom);
      num_bytes = LEN_W'(3);
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      // START + 8 address bits + ACK, then 3 bits into the first data byte.
      repeat ((1 + 9 + 3) * 4 * CLK_DIV) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_scl", int'(scl_o), 1);
      check("rst_sda", int'(sda_o), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_rdy", int'(tx_ready), 0);
      check("rst_nack", int'(nack), 0);
      dn = 0;
      repeat (200) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("rst_no_done", dn, 0);
      check("rst_idle", int'(busy), 0);
   endtask

   initial begin
      int nb;
      int nf;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("init_scl", int'(scl_o), 1);
      check("init_sda", int'(sda_o), 1);
      check("init_busy", int'(busy), 0);
      check("init_done", int'(done), 0);
      check("init_rdy", int'(tx_ready), 0);
      check("init_nack", int'(nack), 0);
      rst_n = 1'b1;

      run_xfer(7'h54, 2, -1, 1'b0, 1'b1);           // two bytes A5, 3C, all ACKed
      run_xfer(7'h2A, 3, 0, 1'b0, 1'b0);            // address NACK
      run_xfer(7'($urandom), 3, 2, 1'b0, 1'b0);     // NACK on data byte 2
      run_xfer(7'($urandom), 0, -1, 1'b0, 1'b0);    // address-only probe (nack must clear)
      run_xfer(7'($urandom), 7, -1, 1'b0, 1'b0);    // clamped to MAX_BYTES
      run_xfer(7'($urandom), 2, -1, 1'b1, 1'b0);    // start held high throughout
      reset_mid();
      run_xfer(7'($urandom), 1, -1, 1'b0, 1'b0);    // normal transfer after reset

      for (int t = 0; t < 10; t++) begin
         nb = int'($urandom_range(0, 7));
         nf = ($urandom_range(0, 1) == 0) ? -1
              : int'($urandom_range(0, (nb > int'(MAX_BYTES)) ? MAX_BYTES : nb));
         run_xfer(7'($urandom), nb, nf, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
